// File: rtl/bringup_uart_bist.sv
// UART built-in self-test for board bringup.
// A character timer launches bytes from a pattern generator onto tx_o. Bytes received on rx_i are
// checked against a prediction of the same pattern, and the block counts transmitted frames, good
// received frames and errors (data mismatches plus framing errors).
module bringup_uart_bist #(
  parameter int unsigned CLOCKS_PER_BAUD = 104,
  parameter int unsigned CLOCKS_PER_CHAR = 120000,
  parameter logic [7:0]  FIRST_CHAR      = 8'd65,
  parameter logic [7:0]  LAST_CHAR       = 8'd90
) (
  input  logic        clock,
  input  logic        reset_n_i,
  input  logic        enable_i,
  input  logic [1:0]  mode_i,
  output logic        tx_o,
  input  logic        rx_i,
  output logic [15:0] tx_count_o,
  output logic [15:0] rx_count_o,
  output logic [15:0] error_count_o,
  output logic        locked_o
);

  localparam int unsigned CHAR_W = (CLOCKS_PER_CHAR > 1) ? $clog2(CLOCKS_PER_CHAR) : 1;
  localparam int unsigned BAUD_W = $clog2(CLOCKS_PER_BAUD);
  localparam logic [CHAR_W-1:0] CHAR_LAST = CHAR_W'(CLOCKS_PER_CHAR - 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BAUD - 1);
  localparam logic [BAUD_W-1:0] HALF_LAST = BAUD_W'(CLOCKS_PER_BAUD / 2 - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} uart_state_t;

  // Pattern successor; shared by the transmit generator and the receive predictor.
  function automatic logic [7:0] gen_next(input logic [7:0] b, input logic [1:0] mode);
    logic [7:0] r;
    case (mode)
      2'd0:    r = ((b < FIRST_CHAR) || (b >= LAST_CHAR)) ? FIRST_CHAR : (b + 8'd1);
      2'd1:    r = (b == 8'h00) ? 8'h01 : {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]};
      2'd2:    r = 8'h55;
      2'd3:    r = 8'h00;
      default: r = 8'h00;
    endcase
    return r;
  endfunction

  // First byte of a pattern after a mode change.
  function automatic logic [7:0] gen_seed(input logic [1:0] mode);
    logic [7:0] r;
    case (mode)
      2'd0:    r = FIRST_CHAR;
      2'd1:    r = 8'h01;
      2'd2:    r = 8'h55;
      2'd3:    r = 8'h00;
      default: r = FIRST_CHAR;
    endcase
    return r;
  endfunction

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  logic [CHAR_W-1:0] char_cnt_q, char_cnt_d;
  uart_state_t       tx_state_q, tx_state_d;
  logic [BAUD_W-1:0] tx_baud_q, tx_baud_d;
  logic [2:0]        tx_bit_q, tx_bit_d;
  logic [7:0]        tx_shift_q, tx_shift_d;
  logic              tx_q, tx_d;
  logic [7:0]        gen_q, gen_d;
  logic [1:0]        last_mode_q, last_mode_d;
  logic [15:0]       tx_count_q, tx_count_d;
  logic              rx_sync1_q, rx_sync1_d, rx_sync2_q, rx_sync2_d, rx_prev_q, rx_prev_d;
  uart_state_t       rx_state_q, rx_state_d;
  logic [BAUD_W-1:0] rx_baud_q, rx_baud_d;
  logic [2:0]        rx_bit_q, rx_bit_d;
  logic [7:0]        rx_shift_q, rx_shift_d;
  logic [15:0]       rx_count_q, rx_count_d;
  logic [15:0]       error_count_q, error_count_d;
  logic              locked_q, locked_d;
  logic [7:0]        expect_q, expect_d;
  logic              launch_s, mode_change_s, frame_good_s, frame_bad_s, locked_rx_s;
  logic [7:0]        tx_byte_s;

  // Free-running character timer; the launch pulse fires on the cycle it wraps back to zero.
  always_comb begin
    launch_s = (char_cnt_q == CHAR_LAST);
    if (launch_s) begin
      char_cnt_d = {CHAR_W{1'b0}};
    end else begin
      char_cnt_d = char_cnt_q + CHAR_W'(1);
    end
  end

  // Transmit FSM: accepts a launch only when idle, then shifts start, 8 data bits LSB first and stop.
  always_comb begin
    tx_state_d    = tx_state_q;
    tx_baud_d     = tx_baud_q;
    tx_bit_d      = tx_bit_q;
    tx_shift_d    = tx_shift_q;
    gen_d         = gen_q;
    last_mode_d   = last_mode_q;
    tx_count_d    = tx_count_q;
    mode_change_s = 1'b0;
    tx_byte_s     = gen_q;
    case (tx_state_q)
      ST_IDLE: begin
        if (launch_s && enable_i) begin
          mode_change_s = (mode_i != last_mode_q);
          tx_byte_s     = mode_change_s ? gen_seed(mode_i) : gen_q;
          tx_shift_d    = tx_byte_s;
          gen_d         = gen_next(tx_byte_s, mode_i);
          last_mode_d   = mode_i;
          tx_count_d    = sat_inc(tx_count_q);
          tx_state_d    = ST_START;
          tx_baud_d     = {BAUD_W{1'b0}};
        end else begin
          tx_state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_state_d = ST_DATA;
          tx_baud_d  = {BAUD_W{1'b0}};
          tx_bit_d   = 3'd0;
        end else begin
          tx_baud_d = tx_baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_baud_d = {BAUD_W{1'b0}};
          if (tx_bit_q == 3'd7) begin
            tx_state_d = ST_STOP;
          end else begin
            tx_bit_d   = tx_bit_q + 3'd1;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
          end
        end else begin
          tx_baud_d = tx_baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (tx_baud_q == BAUD_LAST) begin
          tx_state_d = ST_IDLE;
        end else begin
          tx_baud_d = tx_baud_q + BAUD_W'(1);
        end
      end
      default: tx_state_d = ST_IDLE;
    endcase
    case (tx_state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = tx_shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  // Receive FSM: synchronise rx_i, qualify the start bit at half a bit, then sample at bit centres.
  always_comb begin
    rx_sync1_d   = rx_i;
    rx_sync2_d   = rx_sync1_q;
    rx_prev_d    = rx_sync2_q;
    rx_state_d   = rx_state_q;
    rx_baud_d    = rx_baud_q;
    rx_bit_d     = rx_bit_q;
    rx_shift_d   = rx_shift_q;
    frame_good_s = 1'b0;
    frame_bad_s  = 1'b0;
    case (rx_state_q)
      ST_IDLE: begin
        if (rx_prev_q && !rx_sync2_q) begin
          rx_state_d = ST_START;
          rx_baud_d  = {BAUD_W{1'b0}};
        end else begin
          rx_state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (rx_baud_q == HALF_LAST) begin
          rx_baud_d  = {BAUD_W{1'b0}};
          rx_bit_d   = 3'd0;
          rx_state_d = rx_sync2_q ? ST_IDLE : ST_DATA;
        end else begin
          rx_baud_d = rx_baud_q + BAUD_W'(1);
        end
      end
      ST_DATA: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_baud_d  = {BAUD_W{1'b0}};
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) begin
            rx_state_d = ST_STOP;
          end else begin
            rx_bit_d = rx_bit_q + 3'd1;
          end
        end else begin
          rx_baud_d = rx_baud_q + BAUD_W'(1);
        end
      end
      ST_STOP: begin
        if (rx_baud_q == BAUD_LAST) begin
          rx_state_d   = ST_IDLE;
          frame_good_s = rx_sync2_q;
          frame_bad_s  = !rx_sync2_q;
        end else begin
          rx_baud_d = rx_baud_q + BAUD_W'(1);
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  // Prediction and error accounting; a transmit-side mode change also drops the lock.
  always_comb begin
    rx_count_d    = rx_count_q;
    error_count_d = error_count_q;
    expect_d      = expect_q;
    locked_rx_s   = locked_q;
    if (frame_good_s) begin
      rx_count_d = sat_inc(rx_count_q);
      if (!locked_q) begin
        expect_d    = gen_next(rx_shift_q, mode_i);
        locked_rx_s = 1'b1;
      end else if (rx_shift_q == expect_q) begin
        expect_d = gen_next(rx_shift_q, mode_i);
      end else begin
        error_count_d = sat_inc(error_count_q);
        locked_rx_s   = 1'b0;
      end
    end else if (frame_bad_s) begin
      error_count_d = sat_inc(error_count_q);
      locked_rx_s   = 1'b0;
    end else begin
      locked_rx_s = locked_q;
    end
    locked_d = mode_change_s ? 1'b0 : locked_rx_s;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset_n_i) begin
      char_cnt_q    <= {CHAR_W{1'b0}};
      tx_state_q    <= ST_IDLE;
      tx_baud_q     <= {BAUD_W{1'b0}};
      tx_bit_q      <= 3'd0;
      tx_shift_q    <= 8'h00;
      tx_q          <= 1'b1;
      gen_q         <= FIRST_CHAR;
      last_mode_q   <= 2'd0;
      tx_count_q    <= 16'd0;
      rx_sync1_q    <= 1'b1;
      rx_sync2_q    <= 1'b1;
      rx_prev_q     <= 1'b1;
      rx_state_q    <= ST_IDLE;
      rx_baud_q     <= {BAUD_W{1'b0}};
      rx_bit_q      <= 3'd0;
      rx_shift_q    <= 8'h00;
      rx_count_q    <= 16'd0;
      error_count_q <= 16'd0;
      locked_q      <= 1'b0;
      expect_q      <= 8'h00;
    end else begin
      char_cnt_q    <= char_cnt_d;
      tx_state_q    <= tx_state_d;
      tx_baud_q     <= tx_baud_d;
      tx_bit_q      <= tx_bit_d;
      tx_shift_q    <= tx_shift_d;
      tx_q          <= tx_d;
      gen_q         <= gen_d;
      last_mode_q   <= last_mode_d;
      tx_count_q    <= tx_count_d;
      rx_sync1_q    <= rx_sync1_d;
      rx_sync2_q    <= rx_sync2_d;
      rx_prev_q     <= rx_prev_d;
      rx_state_q    <= rx_state_d;
      rx_baud_q     <= rx_baud_d;
      rx_bit_q      <= rx_bit_d;
      rx_shift_q    <= rx_shift_d;
      rx_count_q    <= rx_count_d;
      error_count_q <= error_count_d;
      locked_q      <= locked_d;
      expect_q      <= expect_d;
    end
  end

  assign tx_o          = tx_q;
  assign tx_count_o    = tx_count_q;
  assign rx_count_o    = rx_count_q;
  assign error_count_o = error_count_q;
  assign locked_o      = locked_q;

endmodule

// File: tb/tb_bringup_uart_bist.sv
// Self-checking bench for bringup_uart_bist with a short bit time and a character period
// shorter than one frame, so every other launch finds the transmitter busy.
module tb_bringup_uart_bist;

  localparam int CPB = 4;
  localparam int CPC = 30;
  localparam logic [7:0] FC = 8'd65;
  localparam logic [7:0] LC = 8'd90;

  logic        clock = 1'b0;
  logic        reset_n_i, enable_i, tx_o, rx_i, locked_o;
  logic [1:0]  mode_i;
  logic [15:0] tx_count_o, rx_count_o, error_count_o;
  logic        loopback, rx_drv;

  typedef struct packed {
    logic [15:0] rx;
    logic [15:0] err;
    logic        lk;
  } stat_t;

  logic [7:0] exp_byte_q[$];
  stat_t      exp_stat_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int unsigned cyc = 0;

  assign rx_i = loopback ? tx_o : rx_drv;

  bringup_uart_bist #(
    .CLOCKS_PER_BAUD(CPB), .CLOCKS_PER_CHAR(CPC), .FIRST_CHAR(FC), .LAST_CHAR(LC)
  ) dut (
    .clock(clock), .reset_n_i(reset_n_i), .enable_i(enable_i), .mode_i(mode_i),
    .tx_o(tx_o), .rx_i(rx_i), .tx_count_o(tx_count_o), .rx_count_o(rx_count_o),
    .error_count_o(error_count_o), .locked_o(locked_o)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  function automatic logic [7:0] model_next(input logic [7:0] b, input logic [1:0] m);
    case (m)
      2'd0:    return ((b < FC) || (b >= LC)) ? FC : b + 8'd1;
      2'd1:    return (b == 8'h00) ? 8'h01 : {b[6:0], b[7] ^ b[5] ^ b[4] ^ b[3]};
      2'd2:    return 8'h55;
      default: return 8'h00;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clock);
    reset_n_i = 1'b0;
    repeat (2) @(negedge clock);
    reset_n_i = 1'b1;
  endtask

  // Wait (bounded) for a start bit on tx_o and sample the frame at bit centres.
  task automatic capture_tx(input bit drop_en, output logic [7:0] b, output logic stop_bit,
                            output int unsigned start_cyc, output bit ok);
    ok = 1'b0; b = 8'h00; stop_bit = 1'b0; start_cyc = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (tx_o === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      start_cyc = cyc;
      if (drop_en) enable_i = 1'b0;
      repeat (CPB / 2) @(negedge clock);
      for (int k = 0; k < 8; k++) begin
        repeat (CPB) @(negedge clock);
        b[k] = tx_o;
      end
      repeat (CPB) @(negedge clock);
      stop_bit = tx_o;
    end
  endtask

  // Drive one frame on rx from the bench, then leave the line idle.
  task automatic send_rx(input logic [7:0] b, input logic stop_bit);
    @(negedge clock);
    rx_drv = 1'b0;
    repeat (CPB) @(negedge clock);
    for (int k = 0; k < 8; k++) begin
      rx_drv = b[k];
      repeat (CPB) @(negedge clock);
    end
    rx_drv = stop_bit;
    repeat (CPB) @(negedge clock);
    rx_drv = 1'b1;
    repeat (3 * CPB) @(negedge clock);
  endtask

  task automatic test_reset();
    loopback = 1'b1; rx_drv = 1'b1; enable_i = 1'b1; mode_i = 2'd0; reset_n_i = 1'b0;
    repeat (3) @(negedge clock);
    n_checks++; if (tx_o !== 1'b1) begin n_fail++; $display("FAIL reset_tx_o: got %b expected 1", tx_o); end
    n_checks++; if (tx_count_o !== 16'd0) begin n_fail++; $display("FAIL reset_tx_count: got %0d expected 0", tx_count_o); end
    n_checks++; if (rx_count_o !== 16'd0) begin n_fail++; $display("FAIL reset_rx_count: got %0d expected 0", rx_count_o); end
    n_checks++; if (error_count_o !== 16'd0) begin n_fail++; $display("FAIL reset_err_count: got %0d expected 0", error_count_o); end
    n_checks++; if (locked_o !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b expected 0", locked_o); end
    enable_i = 1'b0;
    reset_n_i = 1'b1;
  endtask

  // Loop a transmitted stream back and compare every byte against the model sequence.
  task automatic run_loopback(input string name, input logic [1:0] mode, input int nframes,
                              input logic [7:0] first);
    logic [7:0] b, e;
    logic sb;
    int unsigned sc;
    bit ok;
    e = first;
    for (int i = 0; i < nframes; i++) begin
      exp_byte_q.push_back(e);
      e = model_next(e, mode);
    end
    mode_i = mode;
    enable_i = 1'b1;
    for (int i = 0; i < nframes; i++) begin
      capture_tx(1'b0, b, sb, sc, ok);
      if (i == nframes - 1) enable_i = 1'b0;
      n_checks++;
      if (!ok) begin
        n_fail++; $display("FAIL %s_timeout: frame %0d not seen, expected start bit", name, i);
        exp_byte_q.delete();
        break;
      end
      e = exp_byte_q.pop_front();
      n_checks++; if (b !== e) begin n_fail++; $display("FAIL %s_byte: frame %0d got %h expected %h", name, i, b, e); end
      n_checks++; if (sb !== 1'b1) begin n_fail++; $display("FAIL %s_stop: frame %0d got %b expected 1", name, i, sb); end
    end
    repeat (8) @(negedge clock);
  endtask

  task automatic test_loopback_ascending();
    loopback = 1'b1; mode_i = 2'd0; enable_i = 1'b0;
    do_reset();
    run_loopback("asc", 2'd0, 30, FC);
    n_checks++; if (tx_count_o !== 16'd30) begin n_fail++; $display("FAIL asc_tx_count: got %0d expected 30", tx_count_o); end
    n_checks++; if (rx_count_o !== 16'd30) begin n_fail++; $display("FAIL asc_rx_count: got %0d expected 30", rx_count_o); end
    n_checks++; if (error_count_o !== 16'd0) begin n_fail++; $display("FAIL asc_err_count: got %0d expected 0", error_count_o); end
    n_checks++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL asc_locked: got %b expected 1", locked_o); end
  endtask

  task automatic test_loopback_lfsr();
    loopback = 1'b1; mode_i = 2'd1; enable_i = 1'b0;
    do_reset();
    run_loopback("lfsr", 2'd1, 300, 8'h01);
    n_checks++; if (tx_count_o !== 16'd300) begin n_fail++; $display("FAIL lfsr_tx_count: got %0d expected 300", tx_count_o); end
    n_checks++; if (rx_count_o !== 16'd300) begin n_fail++; $display("FAIL lfsr_rx_count: got %0d expected 300", rx_count_o); end
    n_checks++; if (error_count_o !== 16'd0) begin n_fail++; $display("FAIL lfsr_err_count: got %0d expected 0", error_count_o); end
    n_checks++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL lfsr_locked: got %b expected 1", locked_o); end
    // Switching to the constant pattern drops the lock at the launch, then relocks without error.
    run_loopback("const", 2'd2, 1, 8'h55);
    run_loopback("const", 2'd2, 1, 8'h55);
    n_checks++; if (rx_count_o !== 16'd302) begin n_fail++; $display("FAIL const_rx_count: got %0d expected 302", rx_count_o); end
    n_checks++; if (error_count_o !== 16'd0) begin n_fail++; $display("FAIL const_err_count: got %0d expected 0", error_count_o); end
    n_checks++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL const_locked: got %b expected 1", locked_o); end
  endtask

  task automatic test_mode_change_unlock();
    logic [7:0] b;
    logic sb;
    int unsigned sc;
    bit ok;
    mode_i = 2'd0;
    enable_i = 1'b1;
    capture_tx(1'b1, b, sb, sc, ok);
    // The receive side has not yet sampled this frame's stop bit, so only the mode change acts.
    n_checks++; if (locked_o !== 1'b0) begin n_fail++; $display("FAIL modechg_locked: got %b expected 0", locked_o); end
    n_checks++; if (b !== FC) begin n_fail++; $display("FAIL modechg_reseed: got %h expected %h", b, FC); end
    repeat (8) @(negedge clock);
  endtask

  // Bench-driven receive frames; expected status pushed with each frame, popped once it lands.
  task automatic rx_frame(input string name, input logic [7:0] b, input logic stop_bit,
                          input logic [15:0] rxc, input logic [15:0] errc, input logic lk);
    stat_t st, got;
    st.rx = rxc; st.err = errc; st.lk = lk;
    exp_stat_q.push_back(st);
    send_rx(b, stop_bit);
    got.rx = rx_count_o; got.err = error_count_o; got.lk = locked_o;
    st = exp_stat_q.pop_front();
    n_checks++;
    if (got !== st) begin
      n_fail++;
      $display("FAIL %s: got rx=%0d err=%0d lock=%b expected rx=%0d err=%0d lock=%b",
               name, got.rx, got.err, got.lk, st.rx, st.err, st.lk);
    end
  endtask

  task automatic test_rx_mismatch();
    loopback = 1'b0; rx_drv = 1'b1; enable_i = 1'b0; mode_i = 2'd0;
    do_reset();
    rx_frame("mis_A", 8'h41, 1'b1, 16'd1, 16'd0, 1'b1);
    rx_frame("mis_B", 8'h42, 1'b1, 16'd2, 16'd0, 1'b1);
    rx_frame("mis_D", 8'h44, 1'b1, 16'd3, 16'd1, 1'b0);
    rx_frame("mis_E", 8'h45, 1'b1, 16'd4, 16'd1, 1'b1);
    rx_frame("mis_F", 8'h46, 1'b1, 16'd5, 16'd1, 1'b1);
  endtask

  task automatic test_rx_framing();
    stat_t st, got;
    loopback = 1'b0; rx_drv = 1'b1; enable_i = 1'b0; mode_i = 2'd0;
    do_reset();
    rx_frame("frm_good", 8'h41, 1'b1, 16'd1, 16'd0, 1'b1);
    rx_frame("frm_badstop", 8'h41, 1'b0, 16'd1, 16'd1, 1'b0);
    st.rx = 16'd1; st.err = 16'd1; st.lk = 1'b0;
    exp_stat_q.push_back(st);
    @(negedge clock);
    rx_drv = 1'b0;
    repeat (2) @(negedge clock);
    rx_drv = 1'b1;
    repeat (20) @(negedge clock);
    got.rx = rx_count_o; got.err = error_count_o; got.lk = locked_o;
    st = exp_stat_q.pop_front();
    n_checks++;
    if (got !== st) begin
      n_fail++;
      $display("FAIL frm_glitch: got rx=%0d err=%0d lock=%b expected rx=%0d err=%0d lock=%b",
               got.rx, got.err, got.lk, st.rx, st.err, st.lk);
    end
    rx_frame("frm_after", 8'h51, 1'b1, 16'd2, 16'd1, 1'b1);
  endtask

  task automatic test_drop_and_enable();
    logic [7:0] b, e;
    logic sb;
    int unsigned sc, prev_sc;
    bit ok;
    int lows;
    loopback = 1'b1; mode_i = 2'd0; enable_i = 1'b0;
    do_reset();
    e = FC;
    for (int i = 0; i < 5; i++) begin
      exp_byte_q.push_back(e);
      e = model_next(e, 2'd0);
    end
    enable_i = 1'b1;
    prev_sc = 0;
    for (int i = 0; i < 5; i++) begin
      capture_tx(i == 4, b, sb, sc, ok);
      n_checks++;
      if (!ok) begin
        n_fail++; $display("FAIL drop_timeout: frame %0d not seen, expected start bit", i);
        exp_byte_q.delete();
        enable_i = 1'b0;
        break;
      end
      e = exp_byte_q.pop_front();
      n_checks++; if (b !== e) begin n_fail++; $display("FAIL drop_byte: frame %0d got %h expected %h", i, b, e); end
      n_checks++; if (tx_count_o !== 16'(i + 1)) begin n_fail++; $display("FAIL drop_tx_count: frame %0d got %0d expected %0d", i, tx_count_o, i + 1); end
      if (i > 0) begin
        n_checks++;
        if (sc - prev_sc !== 2 * CPC) begin n_fail++; $display("FAIL drop_spacing: frame %0d got %0d expected %0d", i, sc - prev_sc, 2 * CPC); end
      end
      prev_sc = sc;
    end
    lows = 0;
    repeat (300) begin
      @(negedge clock);
      if (tx_o !== 1'b1) lows++;
    end
    n_checks++; if (lows !== 0) begin n_fail++; $display("FAIL disable_tx_idle: got %0d low cycles expected 0", lows); end
    n_checks++; if (tx_count_o !== 16'd5) begin n_fail++; $display("FAIL disable_tx_count: got %0d expected 5", tx_count_o); end
    n_checks++; if (rx_count_o !== 16'd5) begin n_fail++; $display("FAIL disable_rx_count: got %0d expected 5", rx_count_o); end
    n_checks++; if (error_count_o !== 16'd0) begin n_fail++; $display("FAIL disable_err_count: got %0d expected 0", error_count_o); end
  endtask

  task automatic test_reset_midframe();
    bit seen;
    loopback = 1'b1; mode_i = 2'd0; enable_i = 1'b0;
    do_reset();
    run_loopback("pre", 2'd0, 2, FC);
    enable_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (tx_o === 1'b0) begin
        seen = 1'b1;
        break;
      end
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL midrst_timeout: got no start bit expected one"); end
    repeat (12) @(negedge clock);
    n_checks++; if (tx_count_o !== 16'd3) begin n_fail++; $display("FAIL midrst_pre_count: got %0d expected 3", tx_count_o); end
    reset_n_i = 1'b0;
    @(negedge clock);
    n_checks++; if (tx_o !== 1'b1) begin n_fail++; $display("FAIL midrst_tx_o: got %b expected 1", tx_o); end
    n_checks++; if (tx_count_o !== 16'd0) begin n_fail++; $display("FAIL midrst_tx_count: got %0d expected 0", tx_count_o); end
    n_checks++; if (rx_count_o !== 16'd0) begin n_fail++; $display("FAIL midrst_rx_count: got %0d expected 0", rx_count_o); end
    n_checks++; if (error_count_o !== 16'd0) begin n_fail++; $display("FAIL midrst_err_count: got %0d expected 0", error_count_o); end
    n_checks++; if (locked_o !== 1'b0) begin n_fail++; $display("FAIL midrst_locked: got %b expected 0", locked_o); end
    reset_n_i = 1'b1;
    run_loopback("post", 2'd0, 1, FC);
    n_checks++; if (tx_count_o !== 16'd1) begin n_fail++; $display("FAIL post_tx_count: got %0d expected 1", tx_count_o); end
    n_checks++; if (rx_count_o !== 16'd1) begin n_fail++; $display("FAIL post_rx_count: got %0d expected 1", rx_count_o); end
    n_checks++; if (error_count_o !== 16'd0) begin n_fail++; $display("FAIL post_err_count: got %0d expected 0", error_count_o); end
    n_checks++; if (locked_o !== 1'b1) begin n_fail++; $display("FAIL post_locked: got %b expected 1", locked_o); end
  endtask

  initial begin
    test_reset();
    test_loopback_ascending();
    test_loopback_lfsr();
    test_mode_change_unlock();
    test_rx_mismatch();
    test_rx_framing();
    test_drop_and_enable();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
